// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, reset fetch address,
// fetch FSM state encoding and the {instr, pc} payload carried through IF/ID.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_3000;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Drop the byte offset so every fetch address stays word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, ID-side
// stall/redirect handshake, the IF/ID register contents, and two observation
// signals (pending redirect flag and FSM state).
//   master : the fetch stage (drives imem_req/addr and the IF/ID outputs)
//   slave  : memory + ID stage (drives stall/redirect/next_pc and rvalid/rdata)
interface if_fetch_stage_if;
  import mips_pkg::*;

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] next_pc;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;

  logic            redir_pend;
  fetch_state_e    fetch_state;

  modport master (
    input  stall, redirect, next_pc, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4,
           redir_pend, fetch_state
  );

  modport slave (
    output stall, redirect, next_pc, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4,
           redir_pend, fetch_state
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load and clear.
//   clk, rst_n : clock, async active-low reset
//   load       : capture d (takes priority over clear)
//   clear      : drop the valid bit, contents are kept
//   d          : incoming {instr, pc}
//   valid, q   : registered valid flag and payload
//   pc4        : registered q.pc + 4 (wraps modulo 2^32)
module if_id_reg
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  fetch_entry_t    d,
  output logic            valid,
  output fetch_entry_t    q,
  output logic [XLEN-1:0] pc4
);

  logic            valid_q, valid_d;
  fetch_entry_t    entry_q, entry_d;
  logic [XLEN-1:0] pc4_q, pc4_d;

  // Next-value logic: load wins, clear only invalidates.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    pc4_d   = pc4_q;
    if (load) begin
      valid_d = 1'b1;
      entry_d = d;
      pc4_d   = d.pc + INSTR_BYTES;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
      pc4_q   <= INSTR_BYTES;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign q     = entry_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, keeps one request outstanding
// to instruction memory, parks a returning word in a one-entry skid buffer
// when ID stalls, and applies next-PC redirects after the delay slot.
//   clk, reset : clock, async active-low reset
//   bus        : if_fetch_stage_if.master (imem request/response, ID
//                stall/redirect, IF/ID outputs, redir_pend, fetch_state)
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             reset,
  if_fetch_stage_if.master bus
);

  import mips_pkg::XLEN;
  import mips_pkg::INSTR_BYTES;
  import mips_pkg::fetch_state_e;
  import mips_pkg::fetch_entry_t;
  import mips_pkg::IDLE;
  import mips_pkg::REQ;
  import mips_pkg::HOLD;
  import mips_pkg::word_align;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            redir_pend_q, redir_pend_d;
  logic            req_q, req_d;
  fetch_entry_t    skid_q, skid_d;

  logic            id_valid;
  fetch_entry_t    id_entry;
  logic [XLEN-1:0] id_pc4;

  logic            consume_c, accept_c, rvalid_c, redir_cap_c;
  logic            advance_c, load_c, clear_c;
  logic [XLEN-1:0] redir_tgt_c;
  fetch_entry_t    fetched_c, load_entry_c;

  // Handshake terms; rvalid is only meaningful while a request is out.
  assign consume_c   = id_valid & ~bus.stall;
  assign accept_c    = ~id_valid | consume_c;
  assign rvalid_c    = bus.imem_rvalid & req_q;
  assign redir_cap_c = bus.redirect & consume_c;
  assign redir_tgt_c = word_align(bus.next_pc);
  assign fetched_c   = '{instr: bus.imem_rdata, pc: pc_q};

  // Fetch FSM next-state, IF/ID control and PC/redirect update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;
    skid_d       = skid_q;
    advance_c    = 1'b0;
    load_c       = 1'b0;
    load_entry_c = fetched_c;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (rvalid_c) begin
          if (accept_c) begin
            load_c    = 1'b1;
            advance_c = 1'b1;
          end else begin
            skid_d  = fetched_c;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // IF/ID is necessarily full here, so consume frees it for the skid word.
        if (consume_c) begin
          load_c       = 1'b1;
          load_entry_c = skid_q;
          advance_c    = 1'b1;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redir_cap_c) begin
      redir_pc_d = redir_tgt_c;
    end

    // The word loaded on an advance is the delay slot of any captured branch,
    // so a redirect captured in the same cycle applies immediately.
    if (advance_c) begin
      if (redir_pend_q) begin
        pc_d = redir_pc_q;
      end else if (redir_cap_c) begin
        pc_d = redir_tgt_c;
      end else begin
        pc_d = pc_q + INSTR_BYTES;
      end
      redir_pend_d = 1'b0;
    end else if (redir_cap_c) begin
      redir_pend_d = 1'b1;
    end

    req_d = (state_d == REQ);
  end

  assign clear_c = consume_c & ~load_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redir_pc_q   <= '0;
      redir_pend_q <= 1'b0;
      req_q        <= 1'b0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
      req_q        <= req_d;
      skid_q       <= skid_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (reset),
    .load  (load_c),
    .clear (clear_c),
    .d     (load_entry_c),
    .valid (id_valid),
    .q     (id_entry),
    .pc4   (id_pc4)
  );

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = id_valid;
  assign bus.id_instr    = id_entry.instr;
  assign bus.id_pc       = id_entry.pc;
  assign bus.id_pc4      = id_pc4;
  assign bus.redir_pend  = redir_pend_q;
  assign bus.fetch_state = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a variable-latency instruction memory
// model plus hand-computed expectations for sequential fetch, latency,
// delay-slot redirects, stall/skid, mid-request reset and PC wrap.
module tb_if_fetch_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  int unsigned lat = 0;
  logic        force_rv = 1'b0;
  int unsigned wait_cnt;
  int          cyc;
  int          n_checks;
  int          n_errors;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction at address a: 0x24080001 at 0x3000, +1 per word after.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2408_0001 + ((a - 32'h0000_3000) >> 2);
  endfunction

  // Memory responds after `lat` extra cycles; force_rv injects a stray rvalid.
  always_comb begin
    bus.imem_rvalid = force_rv | (bus.imem_req & (wait_cnt >= lat));
    bus.imem_rdata  = bus.imem_req ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_rvalid) wait_cnt <= wait_cnt + 1;
    else                                       wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check_reset(input string t);
    chk({t, " req"},        32'(bus.imem_req),    32'd0);
    chk({t, " addr"},       bus.imem_addr,        32'h0000_3000);
    chk({t, " id_valid"},   32'(bus.id_valid),    32'd0);
    chk({t, " id_instr"},   bus.id_instr,         32'd0);
    chk({t, " id_pc"},      bus.id_pc,            32'd0);
    chk({t, " id_pc4"},     bus.id_pc4,           32'd4);
    chk({t, " redir_pend"}, 32'(bus.redir_pend),  32'd0);
    chk({t, " state"},      32'(bus.fetch_state), 32'(IDLE));
  endtask

  task automatic do_reset(input int unsigned l);
    rst_n        = 1'b0;
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    bus.next_pc  = '0;
    force_rv     = 1'b0;
    lat          = l;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    int          nvalid;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;

    // Reset values, then sequential zero-latency fetch and a taken branch.
    rst_n        = 1'b0;
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    bus.next_pc  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    cyc   = 0;
    chk("a c0 state", 32'(bus.fetch_state), 32'(IDLE));
    chk("a c0 req",   32'(bus.imem_req),    32'd0);
    tick();
    chk("a c1 req",      32'(bus.imem_req), 32'd1);
    chk("a c1 addr",     bus.imem_addr,     32'h0000_3000);
    chk("a c1 id_valid", 32'(bus.id_valid), 32'd0);
    tick();
    chk("a c2 addr",     bus.imem_addr,     32'h0000_3004);
    chk("a c2 id_valid", 32'(bus.id_valid), 32'd1);
    chk("a c2 id_pc",    bus.id_pc,         32'h0000_3000);
    chk("a c2 id_instr", bus.id_instr,      32'h2408_0001);
    chk("a c2 id_pc4",   bus.id_pc4,        32'h0000_3004);
    tick();
    chk("a c3 addr",  bus.imem_addr, 32'h0000_3008);
    chk("a c3 id_pc", bus.id_pc,     32'h0000_3004);
    tick();
    chk("a c4 id_pc", bus.id_pc,     32'h0000_3008);
    chk("a c4 addr",  bus.imem_addr, 32'h0000_300C);
    bus.redirect = 1'b1;
    bus.next_pc  = 32'h0000_3043;
    tick();
    bus.redirect = 1'b0;
    chk("a c5 id_pc",      bus.id_pc,           32'h0000_300C);
    chk("a c5 addr",       bus.imem_addr,       32'h0000_3040);
    chk("a c5 redir_pend", 32'(bus.redir_pend), 32'd0);
    tick();
    chk("a c6 id_pc",    bus.id_pc,     32'h0000_3040);
    chk("a c6 id_instr", bus.id_instr,  mem_word(32'h0000_3040));
    chk("a c6 addr",     bus.imem_addr, 32'h0000_3044);

    // Latency 3: each address held 4 cycles, IF/ID never repeats a PC.
    do_reset(3);
    exp_pc = 32'h0000_3000;
    nvalid = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.id_valid) begin
        chk("b id_pc seq", bus.id_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        nvalid++;
      end
      if (cyc == 4) chk("b c4 addr", bus.imem_addr, 32'h0000_3000);
      if (cyc == 5) chk("b c5 addr", bus.imem_addr, 32'h0000_3004);
      if (cyc == 6) chk("b c6 id_valid", 32'(bus.id_valid), 32'd0);
      if (cyc == 8) chk("b c8 addr", bus.imem_addr, 32'h0000_3004);
      if (cyc == 9) chk("b c9 addr", bus.imem_addr, 32'h0000_3008);
    end
    chk("b valid count", 32'(nvalid), 32'd4);

    // Latency 2: branch at 0x3008 captured before its delay slot returns.
    do_reset(2);
    to_cyc(10);
    chk("c c10 id_pc", bus.id_pc, 32'h0000_3008);
    bus.redirect = 1'b1;
    bus.next_pc  = 32'h0000_3040;
    tick();
    bus.redirect = 1'b0;
    chk("c c11 redir_pend", 32'(bus.redir_pend), 32'd1);
    chk("c c11 id_valid",   32'(bus.id_valid),   32'd0);
    tick();
    chk("c c12 redir_pend", 32'(bus.redir_pend), 32'd1);
    chk("c c12 addr",       bus.imem_addr,       32'h0000_300C);
    tick();
    chk("c c13 redir_pend", 32'(bus.redir_pend), 32'd0);
    chk("c c13 addr",       bus.imem_addr,       32'h0000_3040);
    chk("c c13 id_pc",      bus.id_pc,           32'h0000_300C);
    to_cyc(16);
    chk("c c16 id_pc",    bus.id_pc,    32'h0000_3040);
    chk("c c16 id_instr", bus.id_instr, mem_word(32'h0000_3040));

    // Stall as rvalid arrives: word parked, stray rvalid in HOLD ignored.
    do_reset(0);
    to_cyc(2);
    chk("d c2 id_pc", bus.id_pc, 32'h0000_3000);
    bus.stall = 1'b1;
    tick();
    chk("d c3 state", 32'(bus.fetch_state), 32'(HOLD));
    chk("d c3 req",   32'(bus.imem_req),    32'd0);
    chk("d c3 id_pc", bus.id_pc,            32'h0000_3000);
    force_rv = 1'b1;
    tick();
    tick();
    force_rv = 1'b0;
    chk("d c5 state",    32'(bus.fetch_state), 32'(HOLD));
    chk("d c5 id_valid", 32'(bus.id_valid),    32'd1);
    chk("d c5 id_pc",    bus.id_pc,            32'h0000_3000);
    bus.stall = 1'b0;
    tick();
    chk("d c6 id_pc",    bus.id_pc,            32'h0000_3004);
    chk("d c6 id_instr", bus.id_instr,         mem_word(32'h0000_3004));
    chk("d c6 state",    32'(bus.fetch_state), 32'(REQ));
    chk("d c6 req",      32'(bus.imem_req),    32'd1);
    chk("d c6 addr",     bus.imem_addr,        32'h0000_3008);
    tick();
    chk("d c7 id_pc", bus.id_pc, 32'h0000_3008);

    // Async reset mid-request at 0x3010 with a redirect pending.
    do_reset(2);
    to_cyc(13);
    chk("e c13 id_pc", bus.id_pc, 32'h0000_300C);
    bus.redirect = 1'b1;
    bus.next_pc  = 32'h0000_3080;
    tick();
    bus.redirect = 1'b0;
    chk("e c14 redir_pend", 32'(bus.redir_pend), 32'd1);
    chk("e c14 addr",       bus.imem_addr,       32'h0000_3010);
    chk("e c14 req",        32'(bus.imem_req),   32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    lat   = 0;
    tick();
    chk("e restart addr", bus.imem_addr,     32'h0000_3000);
    chk("e restart req",  32'(bus.imem_req), 32'd1);
    tick();
    chk("e restart id_pc", bus.id_pc, 32'h0000_3000);

    // Redirect to an unaligned top-of-memory target, PC wraps to 0.
    do_reset(0);
    to_cyc(2);
    chk("f c2 id_pc", bus.id_pc, 32'h0000_3000);
    bus.redirect = 1'b1;
    bus.next_pc  = 32'hFFFF_FFFE;
    tick();
    bus.redirect = 1'b0;
    chk("f c3 addr",       bus.imem_addr,       32'hFFFF_FFFC);
    chk("f c3 redir_pend", 32'(bus.redir_pend), 32'd0);
    chk("f c3 id_pc",      bus.id_pc,           32'h0000_3004);
    tick();
    chk("f c4 id_pc",    bus.id_pc,     32'hFFFF_FFFC);
    chk("f c4 id_pc4",   bus.id_pc4,    32'h0000_0000);
    chk("f c4 addr",     bus.imem_addr, 32'h0000_0000);
    chk("f c4 id_instr", bus.id_instr,  mem_word(32'hFFFF_FFFC));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, issues single-outstanding requests to instruction memory, and fills the IF/ID register. It sits directly upstream of the next-PC unit in ID. It supplies that unit with `id_pc4` and accepts its resolved `next_pc` as a redirect, honouring the architectural branch delay slot. It also absorbs variable instruction-memory latency and ID-stage stalls without losing or duplicating instructions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, fetch address after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `stall`  in  1  ID cannot consume IF/ID this cycle.
- `redirect`  in  1  instruction in IF/ID is a taken branch/jump; valid only with `id_valid`.
- `next_pc`  in  32  redirect target from next-PC unit.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address of request (= PC).
- `imem_rvalid`  in  1  read data valid for current request; may arrive in the same cycle as `imem_req` or later.
- `imem_rdata`  in  32  instruction word.
- `id_valid`  out  1  IF/ID holds an unconsumed instruction.
- `id_instr`  out  32  IF/ID instruction.
- `id_pc`  out  32  address of `id_instr`.
- `id_pc4`  out  32  `id_pc + 4`, fed to next-PC unit.

## Operation
- "Consume" means `id_valid & ~stall`. "Accept" means IF/ID is empty or is being consumed in the same cycle.
- FSM states:
  - IDLE: first cycle after reset release. `imem_req`=0. Goes to REQ.
  - REQ: `imem_req`=1 and `imem_addr`=PC, held stable until `imem_rvalid`.
    - On `imem_rvalid` with accept: load IF/ID and advance PC; stay in REQ (back-to-back fetch).
    - On `imem_rvalid` without accept: capture the word and its PC in the skid buffer; go to HOLD.
  - HOLD: `imem_req`=0. On consume, move the skid buffer into IF/ID, advance PC, and go to REQ.
- PC advance: PC becomes the redirect target if one is pending or being captured this cycle; otherwise PC becomes PC+4. A pending redirect clears when it is applied.
- Redirect capture happens when a redirect is consumed: `redirect & id_valid & ~stall`. The target is latched into `redir_pc` and `redir_pend` is set.
  - The target is applied at the next PC advance, i.e. after the delay-slot instruction (branch PC+4) has been fetched.
  - If the delay slot arrives in the capture cycle itself, the target is applied at once and `redir_pend` is never set.
- `next_pc[1:0]` is forced to 0 when captured.
- IF/ID clears (`id_valid`=0) on consume with no new word. Otherwise it holds its contents.
- `imem_rvalid` while `imem_req`=0 is ignored.
- At most one outstanding request and one skid entry exist, so the in-flight fetch is always the sequential successor of the IF/ID instruction.

## Timing
- Reset values:
  - PC = `RESET_PC`; state = IDLE.
  - `imem_req`=0, `id_valid`=0.
  - `id_instr`=0, `id_pc`=0, `id_pc4`=4.
  - `redir_pend`=0; skid buffer empty.
- Reset asserted mid-request drops the request and any pending redirect in the same instant.
- Latency: with a zero-latency memory, the first `imem_req` occurs in cycle 1 after reset release and `id_valid` rises at the end of cycle 1. Throughput is one instruction per cycle.
- Memory latency L extra cycles adds L cycles per instruction. IF/ID is unaffected during the wait.
- Stall with `imem_rvalid` in the same cycle: the word goes to the skid buffer and no instruction is lost. Stall release gives the buffered word in IF/ID one cycle later.
- PC is 32-bit and wraps modulo 2^32, with no exception.

## Structure
- Shared package `mips_pkg`: `RESET_PC` constant and the fetch FSM state enum (IDLE/REQ/HOLD).
- Single module. A sub-module `if_id_reg` (IF/ID register with load/clear) is natural and is reused by later pipeline registers.

## Test plan
- Reset release, zero-latency memory returning `32'h2408_0001` at 0x3000 → `imem_addr` sequence 0x3000, 0x3004, 0x3008 on consecutive cycles; `id_pc`=0x3000 with `id_instr`=0x24080001 at cycle 2.
- Memory latency 3 → each `imem_addr` is held 4 cycles; `id_valid` never shows a duplicate `id_pc`.
- Taken branch at 0x3008 with `next_pc`=0x3040 → `id_pc` sequence 0x3008, 0x300C (delay slot), 0x3040.
- Redirect captured while the delay-slot fetch has latency 2 → `redir_pend`=1 for 2 cycles; the next `imem_addr` is 0x3040.
- `stall` held 3 cycles, asserted as `imem_rvalid` arrives → state HOLD and `imem_req`=0. After release, the word appears in IF/ID with the correct PC and no instruction is skipped.
- `reset` pulsed low mid-request at PC 0x3010 with `redir_pend`=1 → all outputs at reset values; fetch restarts at 0x3000.
